// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester-side handshake and the FIFO push port shared by fifo_wr_arbiter.
// The master modport drives requests and the full flag; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ*DW-1:0] data_i;
    logic [N_REQ-1:0]    last_i;
    logic [N_REQ-1:0]    ready_o;
    logic [N_REQ-1:0]    grant_o;
    logic                busy_o;
    logic                fifo_push_o;
    logic [DW-1:0]       fifo_data_o;
    logic                fifo_full_i;

    modport master (
        output req_i, data_i, last_i, fifo_full_i,
        input  ready_o, grant_o, busy_o, fifo_push_o, fifo_data_o
    );

    modport slave (
        input  req_i, data_i, last_i, fifo_full_i,
        output ready_o, grant_o, busy_o, fifo_push_o, fifo_data_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked arbiter sharing one FIFO write port among N_REQ requesters.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module fifo_wr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int DW    = 8,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_wr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [IW+1:0] N_W    = (IW+2)'(N_REQ);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_REQ - 1);

    state_t           state_r,  state_nxt_s;
    logic [N_REQ-1:0] grant_r,  grant_nxt_s;
    logic [IW-1:0]    gidx_r,   gidx_nxt_s;
    logic [IW-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic             busy_r,   busy_nxt_s;

    logic [IW-1:0]    start_s;
    logic [IW-1:0]    win_s;
    logic             any_req_s;
    logic [N_REQ-1:0] ready_s;
    logic             push_s;
    logic [DW-1:0]    fdata_s;

    // First requester with req set, scanning upward from start and wrapping at N_REQ.
    function automatic logic [IW-1:0] pick_winner(
        input logic [N_REQ-1:0] req,
        input logic [IW-1:0]    start
    );
        logic          found;
        logic [IW-1:0] win;
        logic [IW+1:0] pos;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {2'b00, start} + (IW+2)'(i);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end else begin
                pos = pos;
            end
            if (!found && req[pos[IW-1:0]]) begin
                found = 1'b1;
                win   = pos[IW-1:0];
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Search origin: one past the last packet owner, or always index 0 in fixed priority.
    always_comb begin
        start_s = '0;
`ifdef ARB_FIXED_PRIO_EN
        start_s = '0;
`else
        if (rr_ptr_r == IDX_MAX) begin
            start_s = '0;
        end else begin
            start_s = rr_ptr_r + IW'(1);
        end
`endif
    end

    assign any_req_s = |bus.req_i;
    assign win_s     = pick_winner(bus.req_i, start_s);

    // Next-state logic and the combinational push/ready/data path of the owner.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        gidx_nxt_s   = gidx_r;
        rr_ptr_nxt_s = rr_ptr_r;
        busy_nxt_s   = busy_r;
        ready_s      = '0;
        push_s       = 1'b0;
        fdata_s      = '0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s        = LOCK;
                    grant_nxt_s        = '0;
                    grant_nxt_s[win_s] = 1'b1;
                    gidx_nxt_s         = win_s;
                    busy_nxt_s         = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                    busy_nxt_s  = 1'b0;
                end
            end
            LOCK: begin
                ready_s[gidx_r] = ~bus.fifo_full_i;
                push_s          = bus.req_i[gidx_r] & ~bus.fifo_full_i;
                if (push_s) begin
                    fdata_s = bus.data_i[gidx_r*DW +: DW];
                end else begin
                    fdata_s = '0;
                end
                // The lock only releases on an accepted last beat; stalls just hold it.
                if (push_s && bus.last_i[gidx_r]) begin
                    state_nxt_s  = IDLE;
                    grant_nxt_s  = '0;
                    rr_ptr_nxt_s = gidx_r;
                    busy_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = LOCK;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            gidx_r   <= '0;
            rr_ptr_r <= IDX_MAX;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            gidx_r   <= gidx_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign bus.grant_o     = grant_r;
    assign bus.busy_o      = busy_r;
    assign bus.ready_o     = ready_s;
    assign bus.fifo_push_o = push_s;
    assign bus.fifo_data_o = fdata_s;

endmodule
